// File: rtl/neurondetect_seq_pkg.sv
// Shared constants and FSM encoding for the serial seizure detector family.
package neurondetect_seq_pkg;

  localparam int DEF_N_CH   = 16;
  localparam int DEF_WS_W   = 12;
  localparam int DEF_SUM_W  = 16;
  localparam int DEF_THRESH = 422;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

endpackage

// File: rtl/neuro_persist.sv
// ON/OFF persistence filter: seizure asserts after ON_CNT consecutive above-threshold
// evaluations and clears after OFF_CNT consecutive below-threshold evaluations.
module neuro_persist #(
  parameter int ON_CNT  = 1,
  parameter int OFF_CNT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic eval,
  input  logic above,
  output logic seizure
);

  localparam int ON_W  = $clog2(ON_CNT + 1);
  localparam int OFF_W = $clog2(OFF_CNT + 1);

  logic [ON_W-1:0]  on_c;
  logic [OFF_W-1:0] off_c;
  logic [ON_W-1:0]  on_inc;
  logic [OFF_W-1:0] off_inc;

  // Counters saturate at their target so long runs never wrap back below it.
  assign on_inc  = (on_c == ON_W'(ON_CNT))    ? on_c  : on_c + 1'b1;
  assign off_inc = (off_c == OFF_W'(OFF_CNT)) ? off_c : off_c + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_c    <= '0;
      off_c   <= '0;
      seizure <= 1'b0;
    end else if (!en && eval) begin
      if (above) begin
        on_c  <= on_inc;
        off_c <= '0;
        if (on_inc == ON_W'(ON_CNT)) seizure <= 1'b1;
      end else begin
        off_c <= off_inc;
        on_c  <= '0;
        if (off_inc == OFF_W'(OFF_CNT)) seizure <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/neurondetect_seq.sv
// Serial seizure detector: accumulates N_CH channel sums with one adder, compares the
// total against a captured threshold and feeds the result through a persistence filter.
module neurondetect_seq
  import neurondetect_seq_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int WS_W    = DEF_WS_W,
  parameter int SUM_W   = DEF_SUM_W,
  parameter int ON_CNT  = 1,
  parameter int OFF_CNT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   ws_valid,
  input  logic [N_CH*WS_W-1:0]   ws_data,
  output logic                   ws_ready,
  input  logic [SUM_W-1:0]       thresh,
  output logic [SUM_W-1:0]       sum_out,
  output logic                   sum_valid,
  output logic                   seizure,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_CH);

  if (SUM_W < WS_W + $clog2(N_CH)) begin : g_bad_sum_w
    $error("SUM_W too narrow for N_CH sums of WS_W bits");
  end
  if (N_CH < 2 || ON_CNT < 1 || OFF_CNT < 1) begin : g_bad_params
    $error("N_CH must be >= 2 and ON_CNT/OFF_CNT must be >= 1");
  end

  state_t                    state;
  logic [N_CH*WS_W-1:0]      ws_q;
  logic signed [SUM_W-1:0]   thr_q;
  logic signed [SUM_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic signed [WS_W-1:0]    ch;
  logic                      above;

  assign ch       = ws_q[int'(idx)*WS_W +: WS_W];
  assign above    = (acc >= thr_q);
  assign busy     = (state != ST_IDLE);
  // Held low during reset so every output reads 0 while rst is asserted.
  assign ws_ready = (state == ST_IDLE) && !en && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ws_q      <= '0;
      thr_q     <= '0;
      acc       <= '0;
      idx       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else if (en) begin
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ws_valid) begin
            ws_q  <= ws_data;
            thr_q <= thresh;
            acc   <= '0;
            idx   <= '0;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc <= acc + SUM_W'(ch);
          if (idx == IDX_W'(N_CH - 1)) state <= ST_DECIDE;
          else                         idx   <= idx + 1'b1;
        end
        ST_DECIDE: begin
          sum_out   <= acc;
          sum_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  neuro_persist #(
    .ON_CNT  (ON_CNT),
    .OFF_CNT (OFF_CNT)
  ) u_persist (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .eval    (state == ST_DECIDE),
    .above   (above),
    .seizure (seizure)
  );

endmodule
